branch_history_register: RTL and testbench
==========================================

// Module: branch_history_register
// PURPOSE
//  Global branch-history register feeding the 2-bit `history` index of the branch target buffer.
//  Keeps two histories:
//   - speculative: shifted at fetch with the predicted direction.
//   - committed: shifted at EX with the resolved direction.
//  An in-order FIFO of predicted directions detects mispredicts at resolve and restores the
//  speculative history. Sits between the IF-stage branch detector and the BTB, beside the EX resolve logic.
// PARAMETERS
//  HIST_W  2  history length in bits (>=2); drives BTB entry_addr[1:0] when 2
//  DEPTH   4  max in-flight unresolved branches (power of 2, >=2)
// PORTS
//  clk             in   1       single clock, rising edge
//  rst             in   1       asynchronous, active-high reset
//  fetch_branch    in   1       IF: branch detected (same strobe as BTB access)
//  pred_taken      in   1       IF: predicted direction (BTB state[1])
//  resolve         in   1       EX: oldest in-flight branch resolved (same strobe as BTB update)
//  actual_taken    in   1       EX: resolved direction
//  flush           in   1       external squash of all in-flight branches (e.g. exception)
//  history         out  HIST_W  speculative history -> BTB history input
//  commit_history  out  HIST_W  architectural history
//  mispredict      out  1       comb: resolve && !empty && actual_taken != FIFO head
//  fetch_stall     out  1       comb: in-flight count == DEPTH
//  inflight        out  $clog2(DEPTH)+1  in-flight count
//  resolve_err     out  1       sticky: resolve seen with FIFO empty
//  stat_branches   out  16      resolved-branch counter (0 if BHR_STATS_EN undefined)
//  stat_mispred    out  16      mispredict counter (0 if BHR_STATS_EN undefined)
// BEHAVIOUR
//  - Reset (async, any cycle): histories=0, FIFO empty, inflight=0, resolve_err=0, stats=0.
//    Mid-operation reset discards all in-flight state.
//  - Shift rule: h <= {h[HIST_W-2:0], bit}; new bit enters the LSB, MSB is dropped.
//  - Push (fetch_branch && !fetch_stall): spec <= shift(spec, pred_taken); push pred_taken.
//    Visible on `history` the next cycle. A push while full is dropped; spec is unchanged.
//  - Pop (resolve && !empty): commit <= shift(commit, actual_taken); pop head.
//  - Pop while empty: no state change except resolve_err <= 1.
//  - Mispredict: FIFO emptied, inflight=0, spec <= shift(commit, actual_taken).
//    A same-cycle push is discarded (wrong path).
//  - flush (no mispredict): FIFO emptied, spec <= commit.
//    Same-cycle valid pop still updates commit, and spec <= new commit. Same-cycle push discarded.
//  - Mispredict and flush together: mispredict restore wins (identical FIFO effect).
//  - Simultaneous push and pop, no mispredict/flush: both happen, inflight unchanged.
//    Allowed even when full, because the pop frees the slot in the same cycle.
//  - Pointers: rd/wr are $clog2(DEPTH) bits with natural wrap; count is kept separately.
//  - Latency: history updates 1 cycle after push; mispredict is combinational in the resolve cycle.
// CONFIGURATION
//  BHR_STATS_EN defined:
//   - stat_branches +1 per valid pop.
//   - stat_mispred +1 per mispredict.
//   - Both saturate at 16'hFFFF.
//  BHR_STATS_EN undefined: no counters; both outputs tied to 16'd0.
// STRUCTURE
//  - Shared package bp_pkg:
//    - HIST_W default.
//    - 2-bit predictor state encodings N=00, NT=01, TN=10, T=11.
//    - Typedef hist_t.
//  - Sub-module bhr_dir_fifo: 1-bit-wide DEPTH FIFO.
//    - Inputs: push, pop, clear.
//    - Outputs: head, count, full, empty.
//    - Clear has priority over push.
//  - Top level holds both history registers, restore mux, error flag and stats.
// TESTING
//  1. Reset, then 2 pushes pred=1,0 -> history 00->01->10; inflight=2; commit=00.
//  2. Pushes 1,1, then resolve actual=1,1 -> no mispredict; commit=11; inflight=0.
//  3. Pushes 1,1,0, then resolve actual=0 -> mispredict=1 that cycle; next cycle
//     history=commit<<0=00, inflight=0, commit=00.
//  4. 4 pushes -> fetch_stall=1; 5th push ignored (history unchanged);
//     push+pop same cycle -> inflight stays 4, history shifts.
//  5. resolve with FIFO empty -> resolve_err=1, stays 1 until rst;
//     rst pulse mid-burst -> all outputs 0 immediately.
//  6. BHR_STATS_EN: 3 resolves, 1 mispredict -> stat_branches=3, stat_mispred=1;
//     without the macro -> both 0.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared branch-predictor definitions: default history length, 2-bit counter encodings, history type.
package bp_pkg;

    localparam int BHR_HIST_W = 2;
    localparam int BHR_DEPTH  = 4;

    localparam logic [1:0] PRED_N  = 2'b00;
    localparam logic [1:0] PRED_NT = 2'b01;
    localparam logic [1:0] PRED_TN = 2'b10;
    localparam logic [1:0] PRED_T  = 2'b11;

    typedef logic [BHR_HIST_W-1:0] hist_t;

endpackage

// File: rtl/bhr_dir_fifo.sv
// In-order FIFO of 1-bit predicted directions; clear has priority over push and pop.
module bhr_dir_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = BHR_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     din,
    input  logic                     pop,
    input  logic                     clear,
    output logic                     head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic          mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    assign head  = mem[rd_ptr];
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    // Pointers wrap naturally; the separate count disambiguates full from empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/branch_history_register.sv
// Speculative and committed global branch history with mispredict/flush restore.
// Optional saturating statistics counters when BHR_STATS_EN is defined.
module branch_history_register
    import bp_pkg::*;
#(
    parameter int HIST_W = BHR_HIST_W,
    parameter int DEPTH  = BHR_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fetch_branch,
    input  logic                     pred_taken,
    input  logic                     resolve,
    input  logic                     actual_taken,
    input  logic                     flush,
    output logic [HIST_W-1:0]        history,
    output logic [HIST_W-1:0]        commit_history,
    output logic                     mispredict,
    output logic                     fetch_stall,
    output logic [$clog2(DEPTH):0]   inflight,
    output logic                     resolve_err,
    output logic [15:0]              stat_branches,
    output logic [15:0]              stat_mispred
);

    function automatic logic [HIST_W-1:0] shift_in(input logic [HIST_W-1:0] h, input logic b);
        return {h[HIST_W-2:0], b};
    endfunction

    logic [HIST_W-1:0] spec_hist;
    logic [HIST_W-1:0] commit_hist;
    logic [HIST_W-1:0] commit_next;
    logic              fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop_ok;
    logic              push_ok;
    logic              fifo_clear;

    assign pop_ok      = resolve && !fifo_empty;
    assign mispredict  = pop_ok && (actual_taken != fifo_head);
    assign fetch_stall = fifo_full;
    assign fifo_clear  = mispredict || flush;
    // A pop frees the slot in the same cycle, so push+pop is legal while full.
    assign push_ok     = fetch_branch && (!fifo_full || pop_ok) && !fifo_clear;
    assign commit_next = pop_ok ? shift_in(commit_hist, actual_taken) : commit_hist;

    assign history        = spec_hist;
    assign commit_history = commit_hist;

    bhr_dir_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_ok),
        .din   (pred_taken),
        .pop   (pop_ok),
        .clear (fifo_clear),
        .head  (fifo_head),
        .count (inflight),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Mispredict restore equals shift(commit, actual), which is commit_next when popping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spec_hist   <= '0;
            commit_hist <= '0;
            resolve_err <= 1'b0;
        end else begin
            commit_hist <= commit_next;
            if (fifo_clear)
                spec_hist <= commit_next;
            else if (push_ok)
                spec_hist <= shift_in(spec_hist, pred_taken);
            if (resolve && fifo_empty)
                resolve_err <= 1'b1;
        end
    end

`ifdef BHR_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_branches <= '0;
            stat_mispred  <= '0;
        end else begin
            if (pop_ok)     stat_branches <= sat_inc(stat_branches);
            if (mispredict) stat_mispred  <= sat_inc(stat_mispred);
        end
    end
`else
    assign stat_branches = 16'd0;
    assign stat_mispred  = 16'd0;
`endif

endmodule

// File: tb/tb_branch_history_register.sv
// Directed bench for branch_history_register with a queue-based reference model.
// Stats expectations follow BHR_STATS_EN.
module tb_branch_history_register;

    localparam int HW = 2;
    localparam int DP = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_branch = 1'b0;
    logic        pred_taken = 1'b0;
    logic        resolve = 1'b0;
    logic        actual_taken = 1'b0;
    logic        flush = 1'b0;
    logic [HW-1:0] history;
    logic [HW-1:0] commit_history;
    logic        mispredict;
    logic        fetch_stall;
    logic [2:0]  inflight;
    logic        resolve_err;
    logic [15:0] stat_branches;
    logic [15:0] stat_mispred;

    int checks = 0;
    int errors = 0;

    branch_history_register #(.HIST_W(HW), .DEPTH(DP)) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_branch   (fetch_branch),
        .pred_taken     (pred_taken),
        .resolve        (resolve),
        .actual_taken   (actual_taken),
        .flush          (flush),
        .history        (history),
        .commit_history (commit_history),
        .mispredict     (mispredict),
        .fetch_stall    (fetch_stall),
        .inflight       (inflight),
        .resolve_err    (resolve_err),
        .stat_branches  (stat_branches),
        .stat_mispred   (stat_mispred)
    );

    always #5 clk = ~clk;

    // Reference model: queue of outstanding predictions plus two integer histories.
    bit q[$];
    int m_spec = 0;
    int m_commit = 0;
    int m_err = 0;
    int m_br = 0;
    int m_mp = 0;

    function automatic int shl(input int h, input bit b);
        return ((h << 1) | b) & ((1 << HW) - 1);
    endfunction

    function automatic int exp_mispredict();
        return (resolve && q.size() > 0 && actual_taken != q[0]) ? 1 : 0;
    endfunction

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                q.delete();
                m_spec = 0; m_commit = 0; m_err = 0; m_br = 0; m_mp = 0;
            end else begin
                bit pop, mp, push;
                int newc;
                pop  = resolve && q.size() > 0;
                mp   = pop && (actual_taken != q[0]);
                push = fetch_branch && (q.size() < DP || pop);
                newc = pop ? shl(m_commit, actual_taken) : m_commit;
                if (resolve && q.size() == 0) m_err = 1;
                if (pop && m_br < 65535) m_br++;
                if (mp && m_mp < 65535) m_mp++;
                if (mp || flush) begin
                    q.delete();
                    m_spec = newc;
                end else begin
                    if (pop) void'(q.pop_front());
                    if (push) begin
                        q.push_back(pred_taken);
                        m_spec = shl(m_spec, pred_taken);
                    end
                end
                m_commit = newc;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("m_history", int'(history), m_spec);
        check("m_commit", int'(commit_history), m_commit);
        check("m_inflight", int'(inflight), q.size());
        check("m_stall", int'(fetch_stall), (q.size() == DP) ? 1 : 0);
        check("m_mispredict", int'(mispredict), exp_mispredict());
        check("m_resolve_err", int'(resolve_err), m_err);
`ifdef BHR_STATS_EN
        check("m_stat_br", int'(stat_branches), m_br);
        check("m_stat_mp", int'(stat_mispred), m_mp);
`else
        check("m_stat_br", int'(stat_branches), 0);
        check("m_stat_mp", int'(stat_mispred), 0);
`endif
    end

    task automatic cyc(input bit fb, input bit pt, input bit rs, input bit at, input bit fl);
        fetch_branch = fb; pred_taken = pt; resolve = rs; actual_taken = at; flush = fl;
        @(posedge clk); #1;
        fetch_branch = 0; pred_taken = 0; resolve = 0; actual_taken = 0; flush = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        @(posedge clk); #1;
        do_reset();

        // 1: two pushes 1,0
        check("t1_reset_hist", int'(history), 0);
        check("t1_reset_inflight", int'(inflight), 0);
        cyc(1, 1, 0, 0, 0);
        check("t1_hist_01", int'(history), 1);
        cyc(1, 0, 0, 0, 0);
        check("t1_hist_10", int'(history), 2);
        check("t1_inflight", int'(inflight), 2);
        check("t1_commit", int'(commit_history), 0);

        // 2: correct predictions
        do_reset();
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        resolve = 1; actual_taken = 1; #1;
        check("t2_no_mispredict", int'(mispredict), 0);
        cyc(0, 0, 1, 1, 0);
        cyc(0, 0, 1, 1, 0);
        check("t2_commit", int'(commit_history), 3);
        check("t2_inflight", int'(inflight), 0);
        check("t2_hist", int'(history), 3);

        // 3: mispredict restore
        do_reset();
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        check("t3_spec", int'(history), 2);
        resolve = 1; actual_taken = 0; #1;
        check("t3_mispredict", int'(mispredict), 1);
        cyc(1, 1, 1, 0, 0);
        check("t3_hist_restored", int'(history), 0);
        check("t3_inflight", int'(inflight), 0);
        check("t3_commit", int'(commit_history), 0);

        // 4: full, dropped push, push+pop while full
        do_reset();
        cyc(1, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        check("t4_stall", int'(fetch_stall), 1);
        check("t4_inflight_full", int'(inflight), 4);
        check("t4_hist_full", int'(history), 3);
        cyc(1, 0, 0, 0, 0);
        check("t4_dropped_hist", int'(history), 3);
        check("t4_dropped_inflight", int'(inflight), 4);
        cyc(1, 0, 1, 1, 0);
        check("t4_pushpop_inflight", int'(inflight), 4);
        check("t4_pushpop_hist", int'(history), 2);
        check("t4_pushpop_commit", int'(commit_history), 1);

        // flush with and without a same-cycle pop
        do_reset();
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 1);
        check("flush_hist", int'(history), 0);
        check("flush_inflight", int'(inflight), 0);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 1, 1, 1);
        check("flushpop_commit", int'(commit_history), 1);
        check("flushpop_hist", int'(history), 1);
        check("flushpop_inflight", int'(inflight), 0);

        // 5: resolve on empty, sticky error, async reset mid-burst
        do_reset();
        cyc(0, 0, 1, 1, 0);
        check("t5_err_set", int'(resolve_err), 1);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        check("t5_err_sticky", int'(resolve_err), 1);
        fetch_branch = 1; pred_taken = 1;
        #2 rst = 1'b1;
        #1;
        check("t5_rst_hist", int'(history), 0);
        check("t5_rst_inflight", int'(inflight), 0);
        check("t5_rst_err", int'(resolve_err), 0);
        check("t5_rst_commit", int'(commit_history), 0);
        fetch_branch = 0; pred_taken = 0;
        @(posedge clk); #1;
        rst = 1'b0;

        // 6: three resolves, one mispredict
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(0, 0, 1, 1, 0);
        cyc(0, 0, 1, 1, 0);
        cyc(0, 0, 1, 0, 0);
`ifdef BHR_STATS_EN
        check("t6_stat_br", int'(stat_branches), 3);
        check("t6_stat_mp", int'(stat_mispred), 1);
`else
        check("t6_stat_br", int'(stat_branches), 0);
        check("t6_stat_mp", int'(stat_mispred), 0);
`endif
        check("t6_commit", int'(commit_history), 2);
        check("t6_hist", int'(history), 2);

        repeat (2) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
